// File: rtl/bask_demod.sv
// bask_demod - recovers 8-bit samples from an on-off-keyed BASK line.
//
// Each bit window of BIT_CYC clocks is decoded as 1 when at least EDGE_MIN
// rising edges of the carrier were seen in it. Frames are: start bit (1),
// eight data bits MSB first, stop bit (0). A good frame updates sample and
// pulses valid; a bad start or stop bit pulses frm_err instead.
//
// Ports:
//   clk100khz  in   system clock (only clock)
//   rst        in   synchronous active-high reset
//   BASK       in   received line, asynchronous to clk100khz
//   sample     out  last correctly framed byte, held until the next one
//   valid      out  one-cycle pulse, sample just updated
//   frm_err    out  one-cycle pulse, start or stop bit invalid
//   busy       out  high whenever the FSM is not IDLE
module bask_demod #(
    parameter int BIT_CYC  = 62,
    parameter int EDGE_MIN = 3
) (
    input  logic       clk100khz,
    input  logic       rst,
    input  logic       BASK,
    output logic [7:0] sample,
    output logic       valid,
    output logic       frm_err,
    output logic       busy
);

    localparam int WW = $clog2(BIT_CYC);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic            bask_m;      // first synchronizer flop
    logic            bask_s;
    logic            bask_d;
    logic            rise;
    logic [WW-1:0]   wcnt;
    logic [5:0]      ecnt;
    logic [5:0]      ecnt_nx;
    logic            win_end;
    logic            bit_one;
    logic [2:0]      bidx;
    logic [7:0]      shreg;

    // Edge count for this window including an edge in the current cycle,
    // so the decision at the last window cycle sees it too.
    always_comb begin
        rise    = bask_s & ~bask_d;
        ecnt_nx = (rise && ecnt != 6'd63) ? ecnt + 6'd1 : ecnt;
        win_end = (wcnt == WW'(BIT_CYC - 1));
        bit_one = (ecnt_nx >= 6'(EDGE_MIN));
    end

    always_ff @(posedge clk100khz) begin
        if (rst) begin
            state   <= IDLE;
            bask_m  <= 1'b0;
            bask_s  <= 1'b0;
            bask_d  <= 1'b0;
            wcnt    <= '0;
            ecnt    <= '0;
            bidx    <= '0;
            shreg   <= '0;
            sample  <= '0;
            valid   <= 1'b0;
            frm_err <= 1'b0;
            busy    <= 1'b0;
        end else begin
            bask_m  <= BASK;
            bask_s  <= bask_m;
            bask_d  <= bask_s;
            valid   <= 1'b0;
            frm_err <= 1'b0;

            if (state == IDLE) begin
                wcnt <= '0;
                ecnt <= '0;
                // The detecting cycle is window cycle 0 and its edge counts.
                if (rise) begin
                    state <= START;
                    busy  <= 1'b1;
                    wcnt  <= WW'(1);
                    ecnt  <= 6'd1;
                end
            end else if (!win_end) begin
                wcnt <= wcnt + WW'(1);
                ecnt <= ecnt_nx;
            end else begin
                wcnt <= '0;
                ecnt <= '0;
                case (state)
                    START: begin
                        if (bit_one) begin
                            state <= DATA;
                            bidx  <= 3'd7;
                        end else begin
                            frm_err <= 1'b1;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    DATA: begin
                        shreg <= {shreg[6:0], bit_one};
                        bidx  <= bidx - 3'd1;
                        if (bidx == 3'd0) state <= STOP;
                    end
                    STOP: begin
                        if (!bit_one) begin
                            sample <= shreg;
                            valid  <= 1'b1;
                        end else begin
                            frm_err <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bask_demod.sv
// tb_bask_demod - randomized and directed frames for bask_demod.
// The stimulus side builds the BASK waveform from per-window edge counts,
// predicts each frame outcome from the framing rules, and queues it; a
// monitor pops and compares whenever valid or frm_err appears.
module tb_bask_demod;

    localparam int BIT_CYC  = 62;
    localparam int EDGE_MIN = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       bask;
    logic [7:0] sample;
    logic       valid;
    logic       frm_err;
    logic       busy;

    bask_demod #(.BIT_CYC(BIT_CYC), .EDGE_MIN(EDGE_MIN)) dut (
        .clk100khz (clk),
        .rst       (rst),
        .BASK      (bask),
        .sample    (sample),
        .valid     (valid),
        .frm_err   (frm_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] smp;
        int         at;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] last_good = 8'h00;
    bit         mon_on = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cyc %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: compare every output event against the queued prediction.
    always @(negedge clk) begin
        if (mon_on) begin
            if (valid || frm_err) begin
                chk("evt_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("frm_err", frm_err, e.is_err);
                    chk("valid", valid, !e.is_err);
                    chk("evt_cycle", cyc, e.at);
                    chk("sample", sample, e.smp);
                    chk("busy_at_evt", busy, 0);
                end
            end else if (q.size() > 0 && cyc > q[0].at) begin
                chk("evt_seen", int'(valid | frm_err), 1);
                void'(q.pop_front());
            end
        end
    end

    // Drive one frame described by edge counts per window (start, d7..d0,
    // stop). abort_at >= 0 applies a one-cycle reset at that offset.
    task automatic send_frame(input int ec[10], input int gap, input int abort_at);
        bit         wave[];
        int         len;
        int         p;
        bit         aborted;
        logic [7:0] b;
        exp_t       e;
        len = 10 * BIT_CYC + gap;
        wave = new[len];
        foreach (wave[i]) wave[i] = 1'b0;
        // Each edge is a 5-high/5-low carrier period starting at window
        // offset 0, so every window holds exactly its requested edges.
        for (int k = 0; k < 10; k++)
            for (int i = 0; i < ec[k] && i < 6; i++)
                for (int j = 0; j < 5; j++)
                    wave[k * BIT_CYC + 10 * i + j] = 1'b1;
        aborted = 1'b0;
        for (int o = 0; o < len; o++) begin
            @(negedge clk);
            if (o == 0) begin
                p = cyc;
                if (abort_at < 0) begin
                    // Line rises before edge p+1: window k ends on edge p+64+62k.
                    if (ec[0] < EDGE_MIN) begin
                        e.is_err = 1'b1; e.smp = last_good; e.at = p + 64;
                    end else begin
                        for (int k = 0; k < 8; k++) b[7 - k] = (ec[k + 1] >= EDGE_MIN);
                        e.at = p + 64 + 9 * BIT_CYC;
                        if (ec[9] >= EDGE_MIN) begin
                            e.is_err = 1'b1; e.smp = last_good;
                        end else begin
                            e.is_err = 1'b0; e.smp = b; last_good = b;
                        end
                    end
                    q.push_back(e);
                end
            end
            if (o == 300 && !aborted)
                chk("busy_mid", busy, int'(ec[0] >= EDGE_MIN));
            if (o == abort_at) begin
                rst = 1'b1; bask = 1'b0; aborted = 1'b1;
            end else if (aborted) begin
                if (o == abort_at + 1) begin
                    chk("rst_sample", sample, 0);
                    chk("rst_valid", valid, 0);
                    chk("rst_frm_err", frm_err, 0);
                    chk("rst_busy", busy, 0);
                    last_good = 8'h00;
                end
                rst = 1'b0; bask = 1'b0;
            end else begin
                bask = wave[o];
            end
        end
    endtask

    task automatic byte_frame(input logic [7:0] b, input int on_n, input int off_n,
                              input int stop_n, input int gap, input int abort_at);
        int ec[10];
        ec[0] = 6;
        for (int k = 0; k < 8; k++) ec[k + 1] = b[7 - k] ? on_n : off_n;
        ec[9] = stop_n;
        send_frame(ec, gap, abort_at);
    endtask

    initial begin
        int ec[10];
        logic [7:0] rb;
        rst = 1'b1; bask = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_sample", sample, 0);
        chk("reset_valid", valid, 0);
        chk("reset_frm_err", frm_err, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        mon_on = 1'b1;
        repeat (5) @(negedge clk);

        byte_frame(8'hA5, 6, 0, 0, 40, -1);            // clean frame
        byte_frame(8'h0F, 6, 0, 0, 16, -1);            // back-to-back
        byte_frame(8'h14, 6, 0, 0, 40, -1);
        ec = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};          // false start
        send_frame(ec, 80, -1);
        byte_frame(8'h3C, 6, 0, 6, 40, -1);            // stop-bit violation
        byte_frame(8'h80, 3, 2, 0, 40, -1);            // threshold 3 vs 2
        byte_frame(8'h6B, 3, 2, 2, 40, -1);
        byte_frame(8'hFF, 6, 0, 0, 100, 5 * BIT_CYC + 20); // reset mid-frame
        byte_frame(8'h5A, 6, 0, 0, 40, -1);

        for (int n = 0; n < 12; n++) begin
            rb = 8'($urandom);
            if ($urandom_range(5) == 0) begin
                ec = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
                ec[0] = $urandom_range(2, 1);
            end else begin
                ec[0] = $urandom_range(6, 3);
                for (int k = 0; k < 8; k++)
                    ec[k + 1] = rb[7 - k] ? $urandom_range(6, 3) : $urandom_range(2, 0);
                ec[9] = ($urandom_range(4) == 0) ? $urandom_range(6, 3) : $urandom_range(2, 0);
            end
            send_frame(ec, $urandom_range(40, 16), -1);
        end

        repeat (100) @(negedge clk);
        chk("leftover_expect", q.size(), 0);
        chk("final_busy", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bask_demod.md
# bask_demod

Receive-side counterpart of the BASK PWM modulator. The block recovers 8-bit samples from the 1-bit on-off-keyed BASK line by detecting carrier energy per bit window. It frames each sample and delivers it with a one-cycle valid strobe to downstream sample logic. It runs entirely in the clk100khz domain; the bit rate (≈1.6 kHz) is derived by counting.

## Interface
- BIT_CYC, 62: clk100khz cycles per bit window (100 kHz / 1.6 kHz, truncated).
- EDGE_MIN, 3: minimum carrier rising edges in a window for the bit to decode as 1.
- clk100khz  input  1  system clock, 100 kHz. Only clock in the block.
- rst  input  1  reset. Synchronous and active-high. Clears all state and outputs.
- BASK  input  1  received modulated line, asynchronous to clk100khz.
- sample  output  8  last correctly framed data byte. Holds until the next good frame.
- valid  output  1  one-cycle pulse; sample is updated.
- frm_err  output  1  one-cycle pulse; start or stop bit was invalid.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- Input conditioning: two-flop synchronizer feeds bask_s, and a third flop holds bask_d. An edge is counted in any cycle where bask_s=1 and bask_d=0.
- Frame format, fixed: idle line is low (no carrier), followed by a start bit of 1, 8 data bits MSB first, and a stop bit of 0. 1 = carrier present; 0 = line held low.
- Window counter wcnt runs 0..BIT_CYC-1 and wraps. The edge counter ecnt is 6 bits and saturates at 63.
- Bit decision at wcnt==BIT_CYC-1: the bit is 1 iff ecnt, including any edge in that same cycle, is ≥ EDGE_MIN. ecnt then restarts at 0.
- FSM states:
  - IDLE: wcnt=0, ecnt=0. The first detected edge moves the FSM to START. That cycle is window cycle 0, and the edge counts as 1.
  - START: at the end of the window, a decoded 1 goes to DATA with the bit index at 7. A decoded 0 pulses frm_err and returns to IDLE.
  - DATA: at the end of each window, the decoded bit shifts into shreg at the LSB end, filling MSB first. After the 8th bit, go to STOP.
  - STOP: at the end of the window, a decoded 0 loads sample←shreg, pulses valid, and returns to IDLE. A decoded 1 pulses frm_err, leaves sample unchanged, and returns to IDLE.
- Edges seen in IDLE during the same cycle the FSM returns there are not used. A new frame needs a fresh edge after IDLE is reached.
- rst is sampled on every clock and overrides everything, including mid-frame. After the rst cycle: sample=0x00, valid=0, frm_err=0, busy=0, FSM=IDLE, all counters 0, synchronizer flops 0.
- The block has no back-pressure. valid is a pulse; the consumer must capture sample on it.

## Timing
- Synchronizer latency: a BASK rise before clock edge k produces the edge detect in the cycle after edge k+1. The FSM leaves IDLE on the next clock.
- One frame spans 10·BIT_CYC = 620 cycles from the IDLE→START transition to the STOP-end clock edge.
- valid and frm_err are registered. They are high for exactly the one cycle following the window-end edge. busy falls in that same cycle.
- Minimum gap between frames: one cycle in IDLE plus 3 cycles of synchronizer latency.
- Reset values of all outputs: 0.

## Test plan
- Clean frame: modulate 0xA5 using a carrier of 10-cycle period (≈6 edges per window), frame aligned to BIT_CYC -> exactly one valid, sample=0xA5, frm_err never high, busy low afterwards.
- Back-to-back frames 0x0F then 0x14, gap 16 cycles -> two valid pulses 620 cycles (plus gap) apart, with sample 0x0F then 0x14.
- False start: one 3-cycle high pulse on BASK, then low for 700 cycles -> ecnt=1 < EDGE_MIN in START, one frm_err pulse, no valid, sample unchanged.
- Stop-bit violation: frame 0x3C with carrier kept on during the stop window -> frm_err pulse at STOP end, no valid, sample holds its previous value.
- Threshold boundary: data bit windows with exactly 3 edges and with exactly 2 edges -> decoded as 1 and 0 respectively. Frame 0x80 built this way yields sample=0x80.
- Reset mid-frame: assert rst for 1 cycle at data bit 4 of a frame carrying 0xFF -> all outputs 0 on the next cycle, no valid from the aborted frame, and the next clean frame 0x5A decodes correctly.
